// File: rtl/vdot_seq.sv
// rtl/vdot_seq.sv - long dot-product sequencer around a fixed-latency dot unit
//
// Purpose:
//   Accepts a job of `len` operand word pairs and feeds them one at a time
//   into a dot-product unit with LAT cycles of latency. It accumulates each
//   per-word result into `acc` and pulses `done` when the sum is final.
//   At most one operation is in flight in the unit at any time.
//
// Parameters:
//   CNT_W  width of the job length and the remaining-pair count
//   LAT    unit latency from the vd_en cycle to a valid vd_res (>= 1)
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start, len           job request (sampled in IDLE only) and pair count
//   busy, done           job in progress; one-cycle completion pulse
//   acc, ovf             accumulated result; sticky saturation flag
//   in_valid, in_ready   operand pair handshake
//   in_a, in_b           operand words
//   vd_en, vd_a, vd_b    dot unit enable pulse and held operands
//   vd_res               dot unit result
//
// Configuration:
//   VDOT_SEQ_SAT_EN  defined: saturating unsigned accumulation, ovf is sticky
//                    undefined: accumulation wraps mod 2^32, ovf tied to 0

module vdot_seq #(
  parameter int CNT_W = 8,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      acc,
  output logic             ovf,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             vd_en,
  output logic [31:0]      vd_a,
  output logic [31:0]      vd_b,
  input  logic [31:0]      vd_res
);

  // The wait counter counts LAT down to 0; it must be able to hold LAT.
  localparam int WC_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [WC_W-1:0]  wcnt;
  logic [31:0]      acc_nxt;

`ifdef VDOT_SEQ_SAT_EN
  logic [32:0] sum;
  logic        sum_ovf;

  // A carry out of bit 31 means the unsigned sum no longer fits: clamp.
  assign sum     = {1'b0, acc} + {1'b0, vd_res};
  assign sum_ovf = sum[32];
  assign acc_nxt = sum_ovf ? 32'hFFFF_FFFF : sum[31:0];
`else
  assign acc_nxt = acc + vd_res;
  assign ovf     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= 32'd0;
      in_ready <= 1'b0;
      vd_en    <= 1'b0;
      vd_a     <= 32'd0;
      vd_b     <= 32'd0;
      rem      <= '0;
      wcnt     <= '0;
`ifdef VDOT_SEQ_SAT_EN
      ovf      <= 1'b0;
`endif
    end else begin
      // Single-cycle pulses default low; states raise them when needed.
      vd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= 32'd0;
            busy <= 1'b1;
`ifdef VDOT_SEQ_SAT_EN
            ovf  <= 1'b0;
`endif
            if (len != '0) begin
              rem      <= len;
              in_ready <= 1'b1;
              state    <= S_FETCH;
            end else begin
              // Empty job: report the cleared accumulator immediately.
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_FETCH: begin
          if (in_valid) begin
            vd_a     <= in_a;
            vd_b     <= in_b;
            vd_en    <= 1'b1;
            wcnt     <= WC_W'(LAT);
            in_ready <= 1'b0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          // wcnt equals LAT in the vd_en cycle, so it reaches 0 exactly in
          // the cycle where the unit presents its result.
          if (wcnt == '0) begin
            acc <= acc_nxt;
            rem <= rem - CNT_W'(1);
`ifdef VDOT_SEQ_SAT_EN
            if (sum_ovf) begin
              ovf <= 1'b1;
            end
`endif
            if (rem == CNT_W'(1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= S_FETCH;
            end
          end else begin
            wcnt <= wcnt - WC_W'(1);
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vdot_seq.md
# vdot_seq

Sequencer that computes a long dot product by streaming 32-bit word pairs through the shared 3-cycle vector dot-product unit and accumulating the per-word results. It sits between an operand stream source (valid/ready) and one dot-product unit instance. It owns the unit's enable and operand ports, and reports a 32-bit accumulated result with start/busy/done control.

## Interface
- CNT_W, 8: width of the length field and internal remaining-count.
- LAT, 3: dot-unit latency in cycles from the `vd_en` cycle to a valid `vd_res`; must be ≥ 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  CNT_W  number of word pairs in the job; captured with `start`.
- busy  out  1  high from the cycle after accepted `start` until `done`, inclusive.
- done  out  1  one-cycle pulse when `acc` is final.
- acc  out  32  accumulated result; held after `done` until next accepted `start`.
- ovf  out  1  sticky overflow flag (see Configuration).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a, in_b  in  32  operand words.
- vd_en  out  1  enable to dot unit, one-cycle pulse per pair.
- vd_a, vd_b  out  32  operands to dot unit.
- vd_res  in  32  dot unit result.

## Operation
- States: IDLE, FETCH, WAIT, DONE.
- IDLE:
  - `start=1` with `len≠0`: capture `len` into `rem`, clear `acc` and `ovf`, go to FETCH.
  - `start=1` with `len=0`: clear `acc` and `ovf`, go to DONE.
  - `start` in any other state is ignored.
- FETCH:
  - `in_ready=1`, and only here.
  - On `in_valid & in_ready`: register `in_a`/`in_b` into `vd_a`/`vd_b`, assert `vd_en` the next cycle, load the wait counter with LAT, go to WAIT.
- WAIT:
  - `vd_en` is high only in the first WAIT cycle.
  - `vd_a`/`vd_b` are held stable for the whole of WAIT.
  - The counter decrements each cycle.
  - In the cycle the counter reaches the LAT-th cycle after `vd_en`, sample `vd_res` and update `acc ← acc + vd_res` (mod 2^32), `rem ← rem − 1`.
  - If the new `rem = 0`, go to DONE; otherwise go to FETCH.
- DONE: `done=1` for exactly one cycle, then IDLE.
- Only one operation is ever in flight in the unit; the unit is never re-enabled before its result is captured.
- Reset values: state IDLE, `busy` 0, `done` 0, `acc` 0, `ovf` 0, `in_ready` 0, `vd_en` 0, `vd_a`/`vd_b` 0, `rem` 0.
- Reset mid-job aborts immediately: any in-flight unit result is discarded, and no `done` is produced.

## Timing
- Handshake in cycle H → `vd_en` high in H+1 → `vd_res` captured at end of H+1+LAT → FETCH (`in_ready=1`) in H+2+LAT.
- Per-pair period is LAT+2 cycles minimum (5 at default).
- Job latency with zero-wait source, from the `start` cycle S:
  - FETCH in S+1.
  - `done` in S+1+len·(LAT+2).
  - For `len=0`, `done` in S+1.
- `in_valid` low in FETCH stalls with no state change. Source must hold `in_a`/`in_b` stable while `in_valid=1` and `in_ready=0`.
- `acc` updates only on capture edges; intermediate values are visible but final only at `done`.
- `busy` = state ≠ IDLE.
- `start` in the DONE cycle is ignored; a new job starts at the earliest in the cycle after `done`.
- `rem` wraps never: `len` max 2^CNT_W−1.

## Configuration
- Macro `VDOT_SEQ_SAT_EN`.
- Defined: accumulation is saturating unsigned.
  - If `acc + vd_res` exceeds 32'hFFFF_FFFF, `acc` becomes 32'hFFFF_FFFF and `ovf` is set.
  - `ovf` stays set until the next accepted `start` or reset.
- Undefined: accumulation wraps mod 2^32. `ovf` is tied to 0.

## Test plan
All scenarios use a LAT=3 unit model computing the sum of eight unsigned 4-bit lane products unless stated.
- Reset, then idle: all outputs 0; `in_ready=0`; `start` with `len=0` → `done` in next cycle, `acc=0`, `busy` high only in that cycle.
- `len=3`, pairs (32'h1111_1111, 32'h2222_2222) ×3, source always valid → three `vd_en` pulses 5 cycles apart; `done` at S+16; `acc=32'h30`.
- `len=2`, pairs (32'hFFFF_FFFF, 32'hFFFF_FFFF), (32'h0000_0001, 32'h0000_0003), `in_valid` low 4 cycles before the second pair → `vd_a`/`vd_b` stable through each WAIT; `done` delayed by 4 cycles; `acc=1803`.
- `start` pulsed while busy mid-job with `len=5` → ignored: `rem`/`acc` unaffected, `done` once with the original job's result.
- Assert `rst` in WAIT of the 2nd pair, release, start `len=1` with (32'h0000_0002, 32'h0000_0003) → no `done` from the aborted job; new `acc=6`.
- Stub unit returning 32'h8000_0000, `len=3`:
  - with `VDOT_SEQ_SAT_EN`: `acc=32'hFFFF_FFFF`, `ovf=1`.
  - without: `acc=32'h8000_0000`, `ovf=0`.
